mem_master: RTL and testbench
=============================

MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 The block SHALL have these parameters: WIDTH, default 8, data width; DEPTH, default 32, memory depth, a power of two; ADDR_WIDTH, default $clog2(DEPTH), address width; TIMEOUT, default 15, maximum cycles to wait for ready per beat.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all logic on its rising edge.
- res  in  1  reset; synchronous and active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when it and cmd_valid are both high.
- cmd_wr_rd  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  start address.
- cmd_len  in  ADDR_WIDTH  beats minus one (1..DEPTH beats).
- cmd_seed  in  WIDTH  data pattern base.
- cmd_check  in  1  for reads, 1 = compare read data against the pattern.
- valid  out  1  memory request strobe.
- wr_rd  out  1  memory op, 1 = write.
- addr  out  ADDR_WIDTH  memory address.
- wdata  out  WIDTH  memory write data.
- rdata  in  WIDTH  memory read data.
- ready  in  1  memory completion.
- rsp_valid  out  1  read beat data strobe.
- rsp_data  out  WIDTH  read beat data.
- done  out  1  burst-complete pulse.
- timeout  out  1  burst-aborted pulse.
- err_cnt  out  ADDR_WIDTH+1  read mismatch count of the last burst.

Function
REQ-003 The block SHALL implement the states IDLE, REQ, WAIT and FIN.
REQ-004 cmd_ready SHALL be 1 only in IDLE while res is high, and cmd_valid SHALL be ignored in every other state.
REQ-005 On command acceptance the block SHALL latch all cmd_* fields, clear the beat index and err_cnt, and enter REQ.
REQ-006 In REQ the block SHALL drive valid=1 for exactly one cycle with the latched wr_rd, addr=(cmd_addr+i) mod DEPTH and wdata=(cmd_seed+i) mod 2^WIDTH, where i is the beat index; it SHALL then enter WAIT.
REQ-007 In WAIT valid SHALL be 0, and the first cycle with ready=1 SHALL complete the beat; the nominal beat time is 2 cycles, REQ then WAIT.
REQ-008 On a read-beat completion the block SHALL sample rdata in that cycle, pulse rsp_valid for one cycle on the next cycle with rsp_data set to the sampled value, and, if cmd_check is set and the value differs from (cmd_seed+i) mod 2^WIDTH, increment err_cnt, saturating at all-ones.
REQ-009 After a beat completes the block SHALL return to REQ with i+1 when i<cmd_len, and otherwise enter FIN.
REQ-010 Address wrap SHALL be modulo DEPTH (for example 31 -> 0), and data wrap SHALL be modulo 2^WIDTH.
REQ-011 In FIN the block SHALL pulse done for one cycle and return to IDLE, so that a new command can be accepted on the following cycle.
REQ-012 WAIT SHALL count cycles, and on reaching TIMEOUT cycles without ready the block SHALL abort the burst, pulse timeout and done together for one cycle, and return to IDLE.
REQ-013 A ready=1 seen outside WAIT SHALL be ignored.
REQ-014 err_cnt SHALL hold its value until the next command is accepted, and write bursts SHALL leave it at 0.
REQ-015 valid, wr_rd, addr, wdata, rsp_valid, rsp_data, done and timeout SHALL all be registered outputs.

Reset
REQ-016 While res=0 at a rising edge the block SHALL enter IDLE and drive valid, wr_rd, addr, wdata, rsp_valid, rsp_data, done, timeout, err_cnt and cmd_ready to 0, with the beat index and timeout counter cleared.
REQ-017 A reset mid-burst SHALL abandon the burst without pulsing done or timeout, and cmd_ready SHALL be 1 on the first cycle after res returns high.

Verification
REQ-018 A bench SHALL issue a write burst with addr=30, len=3, seed=0xA0 and check that the memory sees addr/wdata 30/A0, 31/A1, 0/A2, 1/A3, one valid pulse every 2 cycles, and that done pulses once.
REQ-019 A bench SHALL read back with addr=30, len=3, seed=0xA0, check=1 and check rsp_data A0, A1, A2, A3 with four rsp_valid pulses and err_cnt=0.
REQ-020 A bench SHALL read the same range with seed=0xA1, check=1 and check err_cnt=4; the same read with check=0 SHALL give err_cnt=0.
REQ-021 A bench SHALL hold ready at 0 during a read burst and check that timeout and done pulse together TIMEOUT=15 cycles after the valid pulse, with the block back in IDLE and rsp_valid never asserted.
REQ-022 A bench SHALL assert res=0 during beat 2 of a 4-beat write and check that all outputs are 0 on the next edge, that no done pulse occurs, and that cmd_ready=1 once res is high.
REQ-023 A bench SHALL toggle cmd_valid with a new command mid-burst and check that it is ignored, the original burst completes unchanged, and the new command is accepted only once the block is back in IDLE.

Source files
------------

// File: rtl/mem_master.sv
// mem_master: burst memory traffic generator / checker.
//
// Accepts a burst command (write or read, start address, length, data seed)
// and issues one memory request per beat. Beat i targets address
// (cmd_addr + i) mod DEPTH. Its data pattern is (cmd_seed + i) mod 2^WIDTH.
// Read beats return their data on rsp_*. Optionally, each read beat is
// compared against the pattern, and err_cnt counts the mismatches.
// A beat that sees no ready within TIMEOUT cycles aborts the burst.
//
// Ports:
//   clk, res              clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready is high only in IDLE
//   cmd_wr_rd, cmd_addr, cmd_len, cmd_seed, cmd_check   command fields
//   valid, wr_rd, addr, wdata   registered memory request (1-cycle strobe)
//   rdata, ready          memory response
//   rsp_valid, rsp_data   registered read-beat data
//   done, timeout         registered burst-end pulses (timeout implies done)
//   err_cnt               read mismatch count of the last burst (saturating)
module mem_master #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr_rd,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic [WIDTH-1:0]      cmd_seed,
    input  logic                  cmd_check,
    output logic                  valid,
    output logic                  wr_rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH-1:0]      rdata,
    input  logic                  ready,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  done,
    output logic                  timeout,
    output logic [ADDR_WIDTH:0]   err_cnt
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]      wcnt_q, wcnt_d;
    logic                  c_wr_q, c_wr_d;
    logic [ADDR_WIDTH-1:0] c_addr_q, c_addr_d;
    logic [ADDR_WIDTH-1:0] c_len_q, c_len_d;
    logic [WIDTH-1:0]      c_seed_q, c_seed_d;
    logic                  c_chk_q, c_chk_d;
    logic                  valid_q, valid_d;
    logic                  wr_rd_q, wr_rd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]      rsp_data_q, rsp_data_d;
    logic                  done_q, done_d;
    logic                  timeout_q, timeout_d;
    logic [ADDR_WIDTH:0]   err_q, err_d;

    logic [ADDR_WIDTH-1:0] idx_nxt;
    logic [WIDTH-1:0]      exp_data;

    assign cmd_ready = (state_q == S_IDLE) && res;
    assign idx_nxt   = idx_q + ADDR_WIDTH'(1);
    // Pattern value of the beat currently waiting for its response.
    assign exp_data  = c_seed_q + WIDTH'(idx_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wcnt_d      = wcnt_q;
        c_wr_d      = c_wr_q;
        c_addr_d    = c_addr_q;
        c_len_d     = c_len_q;
        c_seed_d    = c_seed_q;
        c_chk_d     = c_chk_q;
        wr_rd_d     = wr_rd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_data_d  = rsp_data_q;
        err_d       = err_q;
        valid_d     = 1'b0;
        rsp_valid_d = 1'b0;
        done_d      = 1'b0;
        timeout_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    c_wr_d   = cmd_wr_rd;
                    c_addr_d = cmd_addr;
                    c_len_d  = cmd_len;
                    c_seed_d = cmd_seed;
                    c_chk_d  = cmd_check;
                    idx_d    = '0;
                    err_d    = '0;
                    // Outputs are registered, so beat 0 is loaded on the
                    // same edge that enters REQ.
                    valid_d  = 1'b1;
                    wr_rd_d  = cmd_wr_rd;
                    addr_d   = cmd_addr;
                    wdata_d  = cmd_seed;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                // The counter tracks cycles since the request strobe, so the
                // abort lands TIMEOUT cycles after valid.
                wcnt_d  = CNT_W'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ready) begin
                    if (!c_wr_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = rdata;
                        if (c_chk_q && (rdata != exp_data) && (err_q != '1))
                            err_d = err_q + (ADDR_WIDTH+1)'(1);
                    end
                    if (idx_q != c_len_q) begin
                        idx_d   = idx_nxt;
                        valid_d = 1'b1;
                        addr_d  = c_addr_q + idx_nxt;
                        wdata_d = c_seed_q + WIDTH'(idx_nxt);
                        state_d = S_REQ;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end
                end else if (wcnt_q >= CNT_W'(TIMEOUT - 1)) begin
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                end
            end
            default: begin
                // FIN: done is high during this cycle.
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            wcnt_q      <= '0;
            c_wr_q      <= 1'b0;
            c_addr_q    <= '0;
            c_len_q     <= '0;
            c_seed_q    <= '0;
            c_chk_q     <= 1'b0;
            valid_q     <= 1'b0;
            wr_rd_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            c_wr_q      <= c_wr_d;
            c_addr_q    <= c_addr_d;
            c_len_q     <= c_len_d;
            c_seed_q    <= c_seed_d;
            c_chk_q     <= c_chk_d;
            valid_q     <= valid_d;
            wr_rd_q     <= wr_rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            err_q       <= err_d;
        end
    end

    assign valid     = valid_q;
    assign wr_rd     = wr_rd_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master. A small memory model answers each request
// one cycle later, unless ready is disabled. A negedge monitor logs requests,
// read responses and done/timeout pulses, and the directed steps check
// those logs against hand-computed values.
module tb_mem_master;

    logic       clk = 1'b0;
    logic       res;
    logic       cmd_valid, cmd_ready, cmd_wr_rd, cmd_check;
    logic [4:0] cmd_addr, cmd_len;
    logic [7:0] cmd_seed;
    logic       valid, wr_rd, ready, rsp_valid, done, timeout;
    logic [4:0] addr;
    logic [7:0] wdata, rdata, rsp_data;
    logic [5:0] err_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    mem_master dut (
        .clk(clk), .res(res),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr_rd(cmd_wr_rd),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
        .cmd_check(cmd_check),
        .valid(valid), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .done(done), .timeout(timeout), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: ready one cycle after each request while ready_en is set;
    // ready_force additionally raises ready outside the wait window.
    logic [7:0] mem [32];
    logic       pending = 1'b0;
    logic       ready_en = 1'b1;
    logic       ready_force = 1'b0;
    assign ready = ready_en & (pending | ready_force);
    assign rdata = mem[addr];
    always @(posedge clk) begin
        if (valid && wr_rd) mem[addr] <= wdata;
        if (valid) pending <= 1'b1;
        else if (ready) pending <= 1'b0;
    end

    // Monitor logs
    logic [4:0] v_addr[$];
    logic [7:0] v_data[$];
    logic       v_wr[$];
    int         v_cyc[$];
    logic [7:0] r_data[$];
    int         done_cnt = 0, to_cnt = 0, to_cyc = 0, dn_cyc = 0;
    logic       cr_at_to = 1'b0;

    always @(negedge clk) begin
        if (valid) begin
            v_addr.push_back(addr);
            v_data.push_back(wdata);
            v_wr.push_back(wr_rd);
            v_cyc.push_back(cyc);
        end
        if (rsp_valid) r_data.push_back(rsp_data);
        if (done) begin
            done_cnt <= done_cnt + 1;
            dn_cyc   <= cyc;
        end
        if (timeout) begin
            to_cnt   <= to_cnt + 1;
            to_cyc   <= cyc;
            cr_at_to <= cmd_ready;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic run_cmd(input logic wr, input logic [4:0] a, input logic [4:0] l,
                           input logic [7:0] s, input logic c);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        cmd_wr_rd = wr; cmd_addr = a; cmd_len = l; cmd_seed = s; cmd_check = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 300) begin tick(1); n++; end
        if (n >= 300) chk("done_wait", 64'(done_cnt), 64'(target));
    endtask

    logic [4:0] exp_addr [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
    logic [7:0] exp_data [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};

    initial begin
        int  b, rb, d0, t0, n;
        logic bad;
        res = 1'b0; cmd_valid = 1'b0; cmd_wr_rd = 1'b0; cmd_addr = '0;
        cmd_len = '0; cmd_seed = '0; cmd_check = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({valid, wr_rd, addr, wdata, rsp_valid, rsp_data,
                                   done, timeout, err_cnt, cmd_ready}), 64'd0);
        @(negedge clk); res = 1'b1; #1;
        chk("ready_after_reset", 64'(cmd_ready), 64'd1);

        // Write burst 30..1 with seed A0, wrapping the address
        b = v_addr.size(); d0 = done_cnt;
        run_cmd(1'b1, 5'd30, 5'd3, 8'hA0, 1'b0);
        wait_done(d0 + 1);
        tick(4);
        chk("wr_done_once", 64'(done_cnt - d0), 64'd1);
        chk("wr_valid_count", 64'(v_addr.size() - b), 64'd4);
        if (v_addr.size() >= b + 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("wr_addr%0d", k), 64'(v_addr[b+k]), 64'(exp_addr[k]));
                chk($sformatf("wr_data%0d", k), 64'(v_data[b+k]), 64'(exp_data[k]));
                chk($sformatf("wr_op%0d", k), 64'(v_wr[b+k]), 64'd1);
            end
            for (int k = 0; k < 3; k++)
                chk($sformatf("wr_gap%0d", k), 64'(v_cyc[b+k+1] - v_cyc[b+k]), 64'd2);
        end
        chk("wr_err_cnt", 64'(err_cnt), 64'd0);

        // Read back with check; ready also held high outside WAIT
        ready_force = 1'b1;
        b = v_addr.size(); rb = r_data.size(); d0 = done_cnt;
        run_cmd(1'b0, 5'd30, 5'd3, 8'hA0, 1'b1);
        wait_done(d0 + 1);
        tick(3);
        ready_force = 1'b0;
        chk("rd_rsp_count", 64'(r_data.size() - rb), 64'd4);
        if (r_data.size() >= rb + 4)
            for (int k = 0; k < 4; k++)
                chk($sformatf("rd_data%0d", k), 64'(r_data[rb+k]), 64'(exp_data[k]));
        if (v_cyc.size() >= b + 4)
            for (int k = 0; k < 3; k++)
                chk($sformatf("rd_gap%0d", k), 64'(v_cyc[b+k+1] - v_cyc[b+k]), 64'd2);
        chk("rd_op", 64'(v_wr[b]), 64'd0);
        chk("rd_err_cnt", 64'(err_cnt), 64'd0);

        // Wrong seed: every beat mismatches; err_cnt holds afterwards
        d0 = done_cnt;
        run_cmd(1'b0, 5'd30, 5'd3, 8'hA1, 1'b1);
        wait_done(d0 + 1);
        tick(5);
        chk("rd_bad_seed_err", 64'(err_cnt), 64'd4);
        d0 = done_cnt;
        run_cmd(1'b0, 5'd30, 5'd3, 8'hA1, 1'b0);
        wait_done(d0 + 1);
        tick(2);
        chk("rd_nocheck_err", 64'(err_cnt), 64'd0);

        // Timeout: no ready at all
        ready_en = 1'b0;
        b = v_addr.size(); rb = r_data.size(); d0 = done_cnt;
        run_cmd(1'b0, 5'd0, 5'd3, 8'h00, 1'b1);
        wait_done(d0 + 1);
        tick(5);
        ready_en = 1'b1;
        chk("to_count", 64'(to_cnt), 64'd1);
        chk("to_valid_count", 64'(v_addr.size() - b), 64'd1);
        if (v_cyc.size() > b) chk("to_latency", 64'(to_cyc - v_cyc[b]), 64'd15);
        chk("to_with_done", 64'(dn_cyc), 64'(to_cyc));
        chk("to_idle", 64'(cr_at_to), 64'd1);
        chk("to_no_rsp", 64'(r_data.size() - rb), 64'd0);

        // Reset during beat 2 of a 4-beat write
        d0 = done_cnt; t0 = to_cnt;
        run_cmd(1'b1, 5'd4, 5'd3, 8'h10, 1'b0);
        n = 0;
        while (!(valid && addr == 5'd5) && n < 50) begin @(negedge clk); n++; end
        chk("rst_reached_beat2", 64'(valid && addr == 5'd5), 64'd1);
        res = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_outputs", 64'({valid, wr_rd, addr, wdata, rsp_valid, rsp_data,
                                     done, timeout, err_cnt, cmd_ready}), 64'd0);
        @(negedge clk); res = 1'b1; #1;
        chk("rst_mid_ready", 64'(cmd_ready), 64'd1);
        tick(20);
        chk("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
        chk("rst_mid_no_to", 64'(to_cnt - t0), 64'd0);

        // Command toggled mid-burst is ignored until IDLE
        b = v_addr.size(); d0 = done_cnt;
        run_cmd(1'b1, 5'd8, 5'd3, 8'h50, 1'b0);
        cmd_addr = 5'd20; cmd_seed = 8'h77; cmd_len = 5'd3; cmd_wr_rd = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cmd_valid = ~cmd_valid;
            #1; if (cmd_ready) bad = 1'b1;
            @(negedge clk);
        end
        chk("mid_ready_low", 64'(bad), 64'd0);
        cmd_valid = 1'b1;
        n = 0;
        while (!done && n < 50) begin @(negedge clk); n++; end
        chk("mid_fin_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk); #1;
        chk("mid_idle_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(d0 + 2);
        tick(2);
        chk("mid_valid_count", 64'(v_addr.size() - b), 64'd8);
        if (v_addr.size() >= b + 5) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("mid_addr%0d", k), 64'(v_addr[b+k]), 64'(8 + k));
                chk($sformatf("mid_data%0d", k), 64'(v_data[b+k]), 64'(8'h50 + k));
            end
            chk("mid_new_addr", 64'(v_addr[b+4]), 64'd20);
            chk("mid_new_data", 64'(v_data[b+4]), 64'h77);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
